// File: rtl/branch_history_tracker_pkg.sv
// Shared definitions for the branch history tracker slice.
//
// Contents:
//   pht_counter_t      2-bit saturating counter encodings held in the PHT
//   PHT_COUNTER_RESET  value every PHT counter starts from
//   HIST_RESET         starting value of both global history registers
//   counter_is_taken() maps a counter value to its taken/not-taken prediction
package branch_history_tracker_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } pht_counter_t;

    localparam pht_counter_t PHT_COUNTER_RESET = WNT;

    localparam int unsigned HIST_RESET = 0;

    // The upper half of the counter range predicts taken.
    function automatic logic counter_is_taken(input pht_counter_t c);
        return (c == WT) || (c == ST);
    endfunction

endpackage

// File: rtl/branch_history_tracker_inflight_fifo.sv
// bp_inflight_fifo: circular buffer of predicted-but-unresolved branches.
// Each entry holds the PHT index used for the lookup and the predicted
// direction, so the resolve path can address the PHT update and detect a
// misprediction.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push                write {push_idx, push_pred} at the tail (ignored when full)
//   push_idx, push_pred entry contents
//   pop                 drop the head entry (ignored when empty)
//   clear               discard every entry; wins over push and pop
//   head_idx, head_pred contents of the oldest entry
//   full, empty, count  occupancy status
//
// DEPTH must be a power of 2 and at least 2 so pointers wrap naturally.
module bp_inflight_fifo #(
    parameter int REGSIZE = 2,
    parameter int DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [REGSIZE-1:0]           push_idx,
    input  logic                         push_pred,
    input  logic                         pop,
    input  logic                         clear,
    output logic [REGSIZE-1:0]           head_idx,
    output logic                         head_pred,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [REGSIZE:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push_ok;
    logic               pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign {head_idx, head_pred} = mem[rd_ptr];

    // Entry storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {push_idx, push_pred};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/branch_history_tracker.sv
// branch_history_tracker: prediction front end and update initiator for a
// 2-bit-counter pattern history table indexed by global history.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   pred_valid      fetch offers a conditional branch for prediction
//   pred_ready      a prediction can be accepted this cycle
//   pht_count       counter read from the PHT at pht_addr
//   predict_taken   prediction derived from pht_count
//   res_valid       execute resolves the oldest in-flight branch
//   res_taken       actual outcome of that branch
//   flush           squash all in-flight branches
//   pht_addr        PHT index: update address while pht_en, else speculative history
//   pht_en          PHT update enable
//   pht_taken       PHT update direction
//   mispredict      one-cycle pulse after a resolve that disagreed with its prediction
//   occupancy       number of in-flight branches
module branch_history_tracker
    import branch_history_tracker_pkg::*;
#(
    parameter int REGSIZE = 2,
    parameter int DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pred_valid,
    output logic                         pred_ready,
    input  logic [1:0]                   pht_count,
    output logic                         predict_taken,
    input  logic                         res_valid,
    input  logic                         res_taken,
    input  logic                         flush,
    output logic [REGSIZE-1:0]           pht_addr,
    output logic                         pht_en,
    output logic                         pht_taken,
    output logic                         mispredict,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    logic [REGSIZE-1:0] spec_hist;
    logic [REGSIZE-1:0] commit_hist;
    logic [REGSIZE-1:0] upd_addr;
    logic [REGSIZE-1:0] spec_next;
    logic [REGSIZE-1:0] commit_next;
    logic [REGSIZE-1:0] head_idx;
    logic               head_pred;
    logic               full;
    logic               empty;
    logic               push_req;
    logic               resolve;
    logic               mispredict_now;
    logic               squash;
    logic               fifo_push;

    assign predict_taken  = counter_is_taken(pht_counter_t'(pht_count));

    // The PHT has a single address port, so lookups stall while it is written.
    assign pred_ready     = !full && !pht_en;
    assign push_req       = pred_valid && pred_ready;
    assign resolve        = res_valid && !empty;
    assign mispredict_now = resolve && (res_taken != head_pred);
    assign squash         = mispredict_now || flush;
    assign fifo_push      = push_req && !squash;

    assign pht_addr       = pht_en ? upd_addr : spec_hist;

    bp_inflight_fifo #(
        .REGSIZE (REGSIZE),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_idx  (spec_hist),
        .push_pred (predict_taken),
        .pop       (resolve),
        .clear     (squash),
        .head_idx  (head_idx),
        .head_pred (head_pred),
        .full      (full),
        .empty     (empty),
        .count     (occupancy)
    );

    // A squash repairs the speculative history from the committed history,
    // including the outcome being resolved in the same cycle.
    always_comb begin
        commit_next = commit_hist;
        spec_next   = spec_hist;
        if (resolve) begin
            commit_next = {commit_hist[REGSIZE-2:0], res_taken};
        end
        if (squash) begin
            spec_next = commit_next;
        end else if (push_req) begin
            spec_next = {spec_hist[REGSIZE-2:0], predict_taken};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spec_hist   <= REGSIZE'(HIST_RESET);
            commit_hist <= REGSIZE'(HIST_RESET);
            upd_addr    <= '0;
            pht_en      <= 1'b0;
            pht_taken   <= 1'b0;
            mispredict  <= 1'b0;
        end else begin
            spec_hist   <= spec_next;
            commit_hist <= commit_next;
            pht_en      <= resolve;
            mispredict  <= mispredict_now;
            if (resolve) begin
                upd_addr  <= head_idx;
                pht_taken <= res_taken;
            end
        end
    end

endmodule

// File: tb/tb_branch_history_tracker.sv
// Directed testbench for branch_history_tracker (REGSIZE=2, DEPTH=4).
// Inputs change 1 time unit after a rising edge; outputs are checked in the
// same quiet window, before the next edge.
module tb_branch_history_tracker;

    logic       clk;
    logic       rst;
    logic       pred_valid;
    logic       pred_ready;
    logic [1:0] pht_count;
    logic       predict_taken;
    logic       res_valid;
    logic       res_taken;
    logic       flush;
    logic [1:0] pht_addr;
    logic       pht_en;
    logic       pht_taken;
    logic       mispredict;
    logic [2:0] occupancy;

    int vectors = 0;
    int miscompares = 0;

    branch_history_tracker #(
        .REGSIZE (2),
        .DEPTH   (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pred_valid    (pred_valid),
        .pred_ready    (pred_ready),
        .pht_count     (pht_count),
        .predict_taken (predict_taken),
        .res_valid     (res_valid),
        .res_taken     (res_taken),
        .flush         (flush),
        .pht_addr      (pht_addr),
        .pht_en        (pht_en),
        .pht_taken     (pht_taken),
        .mispredict    (mispredict),
        .occupancy     (occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic pv, input logic [1:0] pc, input logic rv,
                                 input logic rt, input logic fl, input logic r);
        pred_valid = pv;
        pht_count  = pc;
        res_valid  = rv;
        res_taken  = rt;
        flush      = fl;
        rst        = r;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;

        // 1: reset held for two cycles while other inputs toggle randomly
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'b1);
            tick();
        end
        idle();
        #1;
        checkOutput("rst_pht_addr",   32'(pht_addr),   32'h0);
        checkOutput("rst_pht_en",     32'(pht_en),     32'h0);
        checkOutput("rst_mispredict", 32'(mispredict), 32'h0);
        checkOutput("rst_pred_ready", 32'(pred_ready), 32'h1);
        checkOutput("rst_occupancy",  32'(occupancy),  32'h0);
        checkOutput("rst_pht_taken",  32'(pht_taken),  32'h0);

        // 2: two pushes, then a correct resolve of the oldest
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("t2_pred_wt", 32'(predict_taken), 32'h1);
        tick();
        checkOutput("t2_addr_1", 32'(pht_addr), 32'h1);
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("t2_pred_wnt", 32'(predict_taken), 32'h0);
        tick();
        checkOutput("t2_addr_2", 32'(pht_addr),  32'h2);
        checkOutput("t2_occ_2",  32'(occupancy), 32'h2);
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        checkOutput("t2_upd_en",    32'(pht_en),     32'h1);
        checkOutput("t2_upd_addr",  32'(pht_addr),   32'h0);
        checkOutput("t2_upd_taken", 32'(pht_taken),  32'h1);
        checkOutput("t2_no_mispr",  32'(mispredict), 32'h0);
        checkOutput("t2_occ_1",     32'(occupancy),  32'h1);
        checkOutput("t2_stall",     32'(pred_ready), 32'h0);
        tick();
        checkOutput("t2_en_drop",   32'(pht_en),     32'h0);
        checkOutput("t2_ready",     32'(pred_ready), 32'h1);
        checkOutput("t2_spec_back", 32'(pht_addr),   32'h2);

        // 3: misprediction repairs history from the committed copy
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("t3_addr_1", 32'(pht_addr), 32'h1);
        tick();
        checkOutput("t3_addr_3", 32'(pht_addr), 32'h3);
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        checkOutput("t3_mispr",     32'(mispredict), 32'h1);
        checkOutput("t3_upd_en",    32'(pht_en),     32'h1);
        checkOutput("t3_upd_addr",  32'(pht_addr),   32'h0);
        checkOutput("t3_upd_taken", 32'(pht_taken),  32'h0);
        checkOutput("t3_occ_0",     32'(occupancy),  32'h0);
        tick();
        checkOutput("t3_mispr_end", 32'(mispredict), 32'h0);
        checkOutput("t3_repaired",  32'(pht_addr),   32'h0);
        checkOutput("t3_en_end",    32'(pht_en),     32'h0);

        // 4: fill to DEPTH, a rejected push, then a correct resolve
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("t4_full_occ",   32'(occupancy),  32'h4);
        checkOutput("t4_full_ready", 32'(pred_ready), 32'h0);
        checkOutput("t4_full_addr",  32'(pht_addr),   32'h3);
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("t4_5th_occ",  32'(occupancy), 32'h4);
        checkOutput("t4_5th_hist", 32'(pht_addr),  32'h3);
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        checkOutput("t4_occ_3",    32'(occupancy),  32'h3);
        checkOutput("t4_stall",    32'(pred_ready), 32'h0);
        checkOutput("t4_upd_en",   32'(pht_en),     32'h1);
        checkOutput("t4_upd_addr", 32'(pht_addr),   32'h0);
        checkOutput("t4_no_mispr", 32'(mispredict), 32'h0);
        tick();
        checkOutput("t4_ready",     32'(pred_ready), 32'h1);
        checkOutput("t4_spec_back", 32'(pht_addr),   32'h3);

        // 5: concurrent correct resolve and push, then flush with a dropped push
        applyStimulus(1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        checkOutput("t5_occ_same",  32'(occupancy),  32'h3);
        checkOutput("t5_upd_en",    32'(pht_en),     32'h1);
        checkOutput("t5_upd_addr",  32'(pht_addr),   32'h1);
        checkOutput("t5_no_mispr",  32'(mispredict), 32'h0);
        tick();
        checkOutput("t5_spec_shift", 32'(pht_addr), 32'h2);
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        checkOutput("t5_flush_occ",  32'(occupancy), 32'h0);
        checkOutput("t5_flush_addr", 32'(pht_addr),  32'h3);
        checkOutput("t5_flush_en",   32'(pht_en),    32'h0);
        tick();
        checkOutput("t5_drop_occ",  32'(occupancy), 32'h0);
        checkOutput("t5_drop_addr", 32'(pht_addr),  32'h3);

        // 6: resolve on empty, then reset mid-operation with a resolve pending
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        checkOutput("t6_empty_en",    32'(pht_en),     32'h0);
        checkOutput("t6_empty_mispr", 32'(mispredict), 32'h0);
        checkOutput("t6_empty_occ",   32'(occupancy),  32'h0);
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("t6_occ_2",  32'(occupancy), 32'h2);
        checkOutput("t6_addr_0", 32'(pht_addr),  32'h0);
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        checkOutput("t6_rst_en",    32'(pht_en),     32'h0);
        checkOutput("t6_rst_mispr", 32'(mispredict), 32'h0);
        checkOutput("t6_rst_occ",   32'(occupancy),  32'h0);
        checkOutput("t6_rst_ready", 32'(pred_ready), 32'h1);
        checkOutput("t6_rst_taken", 32'(pht_taken),  32'h0);
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        checkOutput("t6_commit_rst", 32'(pht_addr), 32'h0);
        checkOutput("t6_flush_occ",  32'(occupancy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
